// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings and the request payload used by the SRAM request arbiter.
package sram_req_arbiter_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned SIZE_BITS = 2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam logic [SIZE_BITS-1:0] SIZE_B = 2'b00;
  localparam logic [SIZE_BITS-1:0] SIZE_H = 2'b01;
  localparam logic [SIZE_BITS-1:0] SIZE_W = 2'b10;

  typedef struct packed {
    logic                 wr;
    logic [SIZE_BITS-1:0] size;
    logic [ADDR_W-1:0]    addr;
    logic [STRB_W-1:0]    wstrb;
    logic [DATA_W-1:0]    wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order FIFO of 1-bit transaction owners; push and pop may coincide.
module sram_req_arbiter_owner_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             push_owner_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_owner_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between instruction and data requesters, routing
// in-order responses back to the issuer via an owner FIFO.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ARB_MODE        = ARB_FIXED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_req,
  input  logic                 inst_wr,
  input  logic [SIZE_BITS-1:0] inst_size,
  input  logic [ADDR_W-1:0]    inst_addr,
  input  logic [STRB_W-1:0]    inst_wstrb,
  input  logic [DATA_W-1:0]    inst_wdata,
  output logic                 inst_addr_ok,
  output logic                 inst_data_ok,
  output logic [DATA_W-1:0]    inst_rdata,
  input  logic                 data_req,
  input  logic                 data_wr,
  input  logic [SIZE_BITS-1:0] data_size,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [STRB_W-1:0]    data_wstrb,
  input  logic [DATA_W-1:0]    data_wdata,
  output logic                 data_addr_ok,
  output logic                 data_data_ok,
  output logic [DATA_W-1:0]    data_rdata,
  output logic                 m_req,
  output logic                 m_wr,
  output logic [SIZE_BITS-1:0] m_size,
  output logic [ADDR_W-1:0]    m_addr,
  output logic [STRB_W-1:0]    m_wstrb,
  output logic [DATA_W-1:0]    m_wdata,
  input  logic                 m_addr_ok,
  input  logic                 m_data_ok,
  input  logic [DATA_W-1:0]    m_rdata,
  output logic                 resp_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic             full, empty, head_owner;
  logic [CNT_W-1:0] count;
  logic             rr_last_q, resp_err_q;
  logic             can_issue, grant_data, issue, resp_pop;
  sram_req_t        inst_bus, data_bus, m_bus;

  assign inst_bus = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                      wstrb: inst_wstrb, wdata: inst_wdata};
  assign data_bus = '{wr: data_wr, size: data_size, addr: data_addr,
                      wstrb: data_wstrb, wdata: data_wdata};

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    grant_data = data_req;
    if ((ARB_MODE == ARB_RR) && data_req && inst_req) begin
      grant_data = (rr_last_q == OWNER_INST);
    end
  end

  // Full blocks grants even during a pop, keeping addr_ok free of data_ok.
  assign can_issue = ~full & ~reset;
  assign m_req     = can_issue & (inst_req | data_req);
  assign m_bus     = m_req ? (grant_data ? data_bus : inst_bus) : '0;
  assign m_wr      = m_bus.wr;
  assign m_size    = m_bus.size;
  assign m_addr    = m_bus.addr;
  assign m_wstrb   = m_bus.wstrb;
  assign m_wdata   = m_bus.wdata;

  assign issue        = m_req & m_addr_ok;
  assign data_addr_ok = issue & grant_data;
  assign inst_addr_ok = issue & ~grant_data;

  assign resp_pop     = m_data_ok & (count != '0) & ~reset;
  assign data_data_ok = resp_pop & (head_owner == OWNER_DATA);
  assign inst_data_ok = resp_pop & (head_owner == OWNER_INST);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign resp_err     = resp_err_q;

  sram_req_arbiter_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (issue),
    .push_owner_i (grant_data ? OWNER_DATA : OWNER_INST),
    .pop_i        (resp_pop),
    .head_o       (head_owner),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q  <= OWNER_INST;
      resp_err_q <= 1'b0;
    end else begin
      if (issue) begin
        rr_last_q <= grant_data ? OWNER_DATA : OWNER_INST;
      end
      if (m_data_ok && empty) begin
        resp_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one downstream SRAM-like port (feeding the CPU-to-AXI bridge) between the instruction-fetch and data-access requesters.
- Grants at most one address handshake per cycle and keeps an in-order owner FIFO of outstanding transactions.
- Routes each downstream data_ok and rdata back to the requester that issued it.
- Throttles new grants when the outstanding limit is reached.

Parameters:
- MAX_OUTSTANDING, 4, depth of the owner FIFO; power of two, range 2..16.
- ARB_MODE, 0, 0 = fixed priority (data over inst), 1 = round-robin.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_req/inst_wr  in  1/1  instruction requester request and write flag.
- inst_size  in  2  access size.
- inst_addr  in  32  access address.
- inst_wstrb  in  4  byte strobes.
- inst_wdata  in  32  write data.
- inst_addr_ok/inst_data_ok  out  1/1  address accepted / response delivered to the instruction requester.
- inst_rdata  out  32  read data returned to the instruction requester.
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths and meanings for the data requester.
- m_req/m_wr  out  1/1  downstream request and write flag.
- m_size  out  2  downstream access size.
- m_addr  out  32  downstream address.
- m_wstrb  out  4  downstream byte strobes.
- m_wdata  out  32  downstream write data.
- m_addr_ok  in  1  downstream address accepted.
- m_data_ok  in  1  downstream response valid.
- m_rdata  in  32  downstream read data.
- resp_err  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset:
  - count=0, rd_ptr=wr_ptr=0, rr_last=INST (0), resp_err=0.
  - All *_addr_ok, *_data_ok and m_req are 0 for the whole reset cycle.
- Grant is combinational, recomputed every cycle:
  - can_issue = (count < MAX_OUTSTANDING) & ~reset.
  - ARB_MODE=0: grant DATA if data_req, else INST if inst_req.
  - ARB_MODE=1: when both request, grant the one not equal to rr_last; a single requester is granted directly.
- Downstream port:
  - m_req = can_issue & (inst_req | data_req).
  - m_wr, m_size, m_addr, m_wstrb, m_wdata are muxed from the granted requester; they are 0 when m_req=0.
- Address handshake:
  - issue = m_req & m_addr_ok.
  - The winner's *_addr_ok equals m_addr_ok. The loser's addr_ok is 0.
  - A loser holds its request until it is granted. A requester may drop or change an unaccepted request; the grant follows it the same cycle.
- On issue:
  - fifo[wr_ptr] <= owner (1 bit; 0=INST, 1=DATA).
  - wr_ptr increments, wrapping modulo MAX_OUTSTANDING.
  - rr_last <= owner.
- Response path:
  - Responses are strictly in issue order.
  - When m_data_ok=1 and count>0: owner = fifo[rd_ptr]. That owner's *_data_ok=1 in the same cycle and the other's is 0.
  - rd_ptr increments with wrap.
  - inst_rdata = data_rdata = m_rdata unconditionally. Only data_ok qualifies the data.
- Count update:
  - issue only: +1.
  - response only: -1.
  - both in the same cycle: unchanged, and both pointers advance.
- Full:
  - When count==MAX_OUTSTANDING, m_req=0 even if a response pops that same cycle. This keeps the addr_ok/data_ok paths free of a combinational loop.
  - A new grant is possible the cycle after the pop.
- Empty:
  - m_data_ok with count==0: no data_ok asserted, no pointer or count change.
  - resp_err <= 1 and stays 1 until reset.
- Zero-latency response:
  - A response in the same cycle as its own issue is not allowed. The FIFO head must already be written before the response can pop it.
- Reset mid-operation:
  - All outstanding ownership is discarded.
  - Any responses still in flight downstream after reset deassertion are treated by the empty rule above. The downstream bridge is reset by the same signal, so none are expected.
- Throughput: one issue and one response per cycle sustained.

Decomposition:
- Shared package:
  - OWNER_INST=1'b0, OWNER_DATA=1'b1.
  - ARB_FIXED=0, ARB_RR=1.
  - SRAM size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
- One sub-module: owner_fifo.
  - Parameterized-depth, 1-bit synchronous FIFO with push, pop, count, full and empty.
  - Simultaneous push and pop are legal.
- The arbiter top holds the grant logic, the muxes and resp_err.

Test Plan:
- Fixed mode, both requesters in the same cycle with data_addr=0x1000 and inst_addr=0xBFC00000, m_addr_ok=1 -> m_addr=0x1000, data_addr_ok=1, inst_addr_ok=0. The next cycle m_addr=0xBFC00000 and inst_addr_ok=1. Two m_data_ok pulses give data_data_ok, then inst_data_ok.
- ARB_MODE=1, both requesting continuously, m_addr_ok=1 -> owners alternate DATA,INST,DATA,INST… starting with DATA (rr_last=INST at reset).
- MAX_OUTSTANDING=4, m_addr_ok=1, no m_data_ok -> 4 issues, then m_req=0. One m_data_ok -> a 5th issue the following cycle. Response routing matches issue order.
- Count=2 with a simultaneous issue and m_data_ok -> count stays 2, both pointers advance, and the correct owner gets data_ok.
- m_data_ok with count=0 -> no *_data_ok, resp_err=1 from the next cycle and held. reset=1 -> resp_err=0.
- Data write (data_wr=1, wstrb=4'b0011, wdata=0x1234) interleaved with inst reads -> the m_* fields match the granted requester exactly, and data_data_ok routes to the data requester.
